// File: rtl/thre_pkg.sv
// thre_pkg: threshold word layout and sequencer state encoding
package thre_pkg;
  localparam int THRE_W     = 24;
  localparam int PLUS_SIGN  = 23;
  localparam int PLUS_HI    = 22;
  localparam int PLUS_LO    = 12;
  localparam int MINUS_SIGN = 11;
  localparam int MINUS_HI   = 10;
  localparam int MINUS_LO   = 0;
  typedef enum logic [2:0] {FILL, FULL, SETUP, PULSE, HOLD} state_t;
endpackage

// File: rtl/thre_byte_packer.sv
// thre_byte_packer: assembles three MSB-first bytes into one threshold word
module thre_byte_packer
  import thre_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              take,
  input  logic [7:0]        s_byte,
  output logic [THRE_W-1:0] word,
  output logic              word_valid
);
  logic [1:0]  cnt;
  logic [15:0] sh;
  assign word_valid = take && cnt == 2'd2;
  assign word = {sh, s_byte};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= word_valid ? 2'd0 : cnt + 2'd1;
      sh  <= {sh[7:0], s_byte};
    end
endmodule

// File: rtl/thre_load_seq.sv
// thre_load_seq: buffers one threshold per channel and replays them with one-hot load strobes
module thre_load_seq
  import thre_pkg::*;
#(
  parameter int NUM_CH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_byte,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              issue,
  input  logic              clr,
  output logic [THRE_W-1:0] threhold,
  output logic [NUM_CH-1:0] loadthrehold,
  output logic              buf_full,
  output logic              busy,
  output logic              done
);
  localparam int CH_W = $clog2(NUM_CH);
  state_t              state, state_d;
  logic [CH_W-1:0]     wptr, ch;
  logic [THRE_W-1:0]   mem [NUM_CH];
  logic [THRE_W-1:0]   word, thre_d;
  logic [NUM_CH-1:0]   load_d;
  logic                take, wv, last_w, last_ch;
  logic                s_ready_d, buf_full_d, busy_d, done_d;
  assign take    = s_valid && s_ready && !clr && state == FILL;
  assign last_w  = wptr == CH_W'(NUM_CH - 1);
  assign last_ch = ch == CH_W'(NUM_CH - 1);
  thre_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .take       (take),
    .s_byte     (s_byte),
    .word       (word),
    .word_valid (wv)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else        state <= state_d;
  always_comb
    state_d = clr                            ? FILL  :
              (state == FILL && wv && last_w) ? FULL  :
              (state == FULL && issue)        ? SETUP :
              state == SETUP                  ? PULSE :
              state == PULSE                  ? HOLD  :
              state == HOLD                   ? (last_ch ? FILL : SETUP) :
                                                state;
  // next values of the registered outputs, so strobes come straight from flops
  always_comb begin
    s_ready_d  = state_d == FILL;
    buf_full_d = state_d != FILL;
    busy_d     = state_d inside {SETUP, PULSE, HOLD};
    load_d     = (!clr && state == PULSE) ? NUM_CH'(1) << ch : '0;
    thre_d     = (!clr && state == SETUP) ? mem[ch] : threhold;
    done_d     = !clr && state == HOLD && last_ch;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_ready      <= 1'b0;
      threhold     <= '0;
      loadthrehold <= '0;
      buf_full     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      s_ready      <= s_ready_d;
      threhold     <= thre_d;
      loadthrehold <= load_d;
      buf_full     <= buf_full_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      ch   <= '0;
    end else if (clr) begin
      wptr <= '0;
    end else begin
      if (wv)                                wptr <= last_w ? '0 : wptr + CH_W'(1);
      else if (state == HOLD && last_ch)     wptr <= '0;
      if (state == FULL && issue)            ch <= '0;
      else if (state == HOLD && !last_ch)    ch <= ch + CH_W'(1);
    end
  always_ff @(posedge clk)
    if (wv) mem[wptr] <= word;
endmodule

// File: tb/tb_thre_load_seq.sv
// tb_thre_load_seq: randomized fill/replay checks against a timing-rule reference model
module tb_thre_load_seq;
  localparam int N = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_byte = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          issue = 1'b0;
  logic          clr = 1'b0;
  logic [23:0]   threhold;
  logic [N-1:0]  loadthrehold;
  logic          buf_full, busy, done;
  logic [23:0]   next_w [N];
  logic [23:0]   exp_mem [N];
  int            n_cmp = 0;
  int            n_bad = 0;

  thre_load_seq #(.NUM_CH(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_byte       (s_byte),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .issue        (issue),
    .clr          (clr),
    .threhold     (threhold),
    .loadthrehold (loadthrehold),
    .buf_full     (buf_full),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int i);
    logic [23:0] w;
    w = next_w[i / 3];
    return w[23 - 8 * (i % 3) -: 8];
  endfunction

  // sends the first nb bytes of next_w; rnd adds valid gaps and stray issue pulses
  task automatic send_bytes(input int nb, input bit rnd);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < nb && cyc < 4000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_byte  = byte_of(i);
      issue   = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      acc     = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
      chk("fill_load", 64'(loadthrehold), 64'(0));
      chk("fill_busy", 64'(busy), 64'(0));
      chk("fill_rdy", 64'(s_ready), 64'(i != 3 * N));
      chk("fill_full", 64'(buf_full), 64'(i == 3 * N));
    end
    s_valid = 1'b0;
    issue   = 1'b0;
    if (i < nb) chk("fill_timeout", 64'(i), 64'(nb));
    if (nb == 3 * N) exp_mem = next_w;
  endtask

  // issue at E0, then check every edge up to E(stop)
  task automatic replay(input int stop, input bit noise);
    logic [N-1:0] exp_load;
    issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0;
    chk("e0_busy", 64'(busy), 64'(1));
    for (int t = 1; t <= stop; t++) begin
      issue = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #1;
      exp_load = (t % 3 == 2) ? N'(1) << ((t - 2) / 3) : '0;
      chk("rp_load", 64'(loadthrehold), 64'(exp_load));
      chk("rp_thre", 64'(threhold), 64'(exp_mem[(t - 1) / 3]));
      chk("rp_busy", 64'(busy), 64'(t < 3 * N));
      chk("rp_done", 64'(done), 64'(t == 3 * N));
      chk("rp_rdy", 64'(s_ready), 64'(t == 3 * N));
      chk("rp_full", 64'(buf_full), 64'(t < 3 * N));
      chk("rp_onehot", 64'($countones(loadthrehold) <= 1), 64'(1));
    end
    issue = 1'b0;
  endtask

  task automatic rand_words();
    for (int k = 0; k < N; k++) next_w[k] = 24'($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(s_ready), 64'(0));
    chk("rst_thre", 64'(threhold), 64'(0));
    chk("rst_load", 64'(loadthrehold), 64'(0));
    chk("rst_flags", 64'({buf_full, busy, done}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy", 64'(s_ready), 64'(1));

    for (int k = 0; k < N; k++) next_w[k] = 24'h800000 + 24'(k);
    send_bytes(3 * N, 1'b0);
    repeat (3) begin
      issue = 1'b0;
      @(posedge clk); #1;
      chk("full_idle_load", 64'(loadthrehold), 64'(0));
      chk("full_hold", 64'({s_ready, buf_full}), 64'(1));
    end
    replay(3 * N, 1'b1);
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'(0));

    rand_words();
    next_w[0] = 24'hA5C3F0;
    send_bytes(3 * N, 1'b1);
    replay(3 * N, 1'b1);

    rand_words();
    send_bytes(3 * N, 1'b1);
    replay(7, 1'b0);
    clr = 1'b1; s_valid = 1'b1; s_byte = 8'($urandom); issue = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; s_valid = 1'b0; issue = 1'b0;
    chk("clr_load", 64'(loadthrehold), 64'(0));
    chk("clr_busy", 64'(busy), 64'(0));
    chk("clr_rdy", 64'(s_ready), 64'(1));
    chk("clr_full", 64'(buf_full), 64'(0));
    chk("clr_thre", 64'(threhold), 64'(exp_mem[2]));

    rand_words();
    send_bytes(4, 1'b1);
    clr = 1'b1; s_valid = 1'b1; s_byte = 8'($urandom);
    @(posedge clk); #1;
    clr = 1'b0; s_valid = 1'b0;
    chk("clr2_rdy", 64'(s_ready), 64'(1));
    rand_words();
    send_bytes(3 * N, 1'b1);
    replay(3 * N, 1'b0);

    rand_words();
    send_bytes(3 * N, 1'b1);
    replay(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load", 64'(loadthrehold), 64'(0));
    chk("arst_flags", 64'({busy, done, buf_full, s_ready}), 64'(0));
    chk("arst_thre", 64'(threhold), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_rdy", 64'(s_ready), 64'(1));
    rand_words();
    send_bytes(3 * N, 1'b1);
    replay(3 * N, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/thre_load_seq.md
# thre_load_seq

Threshold loader and sequencer: the writer side of the compare-block threshold interface. It accepts a byte stream of packed 24-bit threshold words from the host/config path and buffers one word per output channel. On command, it replays the words onto the shared threshold bus, giving each comparator its own load strobe. It sits between the configuration port and the NUM_CH compare blocks of the binarising output layer.

## Interface
- NUM_CH, 16, number of compare blocks (channels) served; ≥2
- CH_W, $clog2(NUM_CH), channel index width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_byte  in  8  threshold byte, MSB-first within each word
- s_valid  in  1  s_byte valid
- s_ready  out  1  byte accepted on any edge with s_valid && s_ready
- issue  in  1  single-cycle request to replay the buffer to the comparators
- clr  in  1  synchronous flush; has priority over everything except reset
- threhold  out  24  shared threshold bus: {plus_sign, thre_plus[10:0], minus_sign, thre_minus[10:0]}
- loadthrehold  out  NUM_CH  one-hot load strobes; consumers latch threhold on the rising edge
- buf_full  out  1  all NUM_CH words buffered
- busy  out  1  replay in progress
- done  out  1  one-cycle pulse at the end of replay

## Operation
- All outputs are registered. Reset values: s_ready=0, threhold=0, loadthrehold=0, buf_full=0, busy=0, done=0. State after reset is FILL, wptr=0, byte count=0.
- Consumers use loadthrehold as a clock edge. Strobes must therefore be glitch-free flop outputs: at most one bit high, never two bits changing on the same edge.
- FILL:
  - s_ready=1, starting from the first edge after rst_n is released.
  - Bytes assemble MSB-first: byte0→[23:16], byte1→[15:8], byte2→[7:0].
  - On the third byte, write mem[wptr] and increment wptr.
  - When wptr reaches NUM_CH, go to FULL. s_ready falls on the same edge that accepts the last byte.
- FULL:
  - s_ready=0, buf_full=1.
  - issue → SETUP with ch=0. issue is ignored in every state other than FULL; it is not queued.
- SETUP: threhold ← mem[ch], loadthrehold=0 → PULSE.
- PULSE: loadthrehold ← one-hot(ch) → HOLD.
- HOLD: loadthrehold ← 0, threhold held.
  - If ch==NUM_CH-1: done ← 1, buf_full ← 0, wptr ← 0, go to FILL.
  - Otherwise ch++ and go to SETUP.
- busy=1 in SETUP/PULSE/HOLD. s_ready=0 throughout replay.
- Buffer contents persist after replay. A new fill overwrites them from index 0.
- clr:
  - Next edge: wptr=0, byte count=0, loadthrehold=0, buf_full=0, busy=0, state=FILL.
  - threhold keeps its last value.
  - A byte presented on the clr cycle is discarded.
  - clr together with issue: clr wins.
- Reset mid-replay: all outputs go to reset values immediately. Channels not yet strobed keep their stale thresholds. This is acceptable; software re-issues.
- No arithmetic on field contents: words pass through bit-exact.

## Timing
- Let E0 be the edge that samples issue in FULL. Then for channel k:
  - threhold = word k from E(1+3k)
  - loadthrehold[k] rises at E(2+3k) and falls at E(3+3k)
  - word k+1 appears at E(4+3k)
- Threhold is therefore stable ≥1 cycle before and ≥1 cycle after every strobe rising edge.
- done is high for one cycle from E(3·NUM_CH). s_ready returns at E(3·NUM_CH).
- Total replay: 3·NUM_CH cycles.
- Fill takes at least 3·NUM_CH accepted bytes. Stalls on s_valid are unbounded, and the partial byte count is held across stalls.

## Structure
- Package thre_pkg:
  - THRE_W=24
  - field constants PLUS_SIGN=23, PLUS_HI=22, PLUS_LO=12, MINUS_SIGN=11, MINUS_HI=10, MINUS_LO=0
  - state enum {FILL, FULL, SETUP, PULSE, HOLD}
- Sub-module thre_byte_packer: 3-byte → 24-bit assembler. It holds the byte counter and shift register, emits a word_valid pulse, and clears on clr.
- Top level holds mem[NUM_CH] (flops), wptr, ch, the FSM and the output registers.

## Test plan
- Reset release, then 48 bytes for words 0x800000+k (NUM_CH=16) → s_ready drops on the 48th accept; buf_full=1; no strobe activity.
- issue at E0 → threhold=0x800000 at E1, loadthrehold=0x0001 at E2 and 0 at E3, threhold=0x800001 at E4; done pulse at E48; never two strobe bits set.
- issue during FILL, and issue during replay → ignored: no strobe; replay timing unchanged.
- s_valid toggling randomly while filling word 0xA5C3F0 → stored word exact; byte order MSB-first.
- clr at E7 of replay → loadthrehold=0 and busy=0 at E8; s_ready=1; threhold keeps its last word; the next fill starts at index 0.
- rst_n asserted mid-PULSE → loadthrehold, busy and done are 0 asynchronously; after release, state is FILL with wptr=0.
